// File: rtl/nv_nvdla_ssync_bank.sv
// Multi-channel level synchroniser into the o_clk domain with registered rise/fall/change pulses.
// Optional per-channel stability filter compiled in by defining NVDLA_SSYNC_FILTER_EN.
module nv_nvdla_ssync_bank #(
    parameter int unsigned       WIDTH    = 1,
    parameter int unsigned       STAGES   = 3,
    parameter logic [WIDTH-1:0]  RST_VAL  = '0,
    parameter int unsigned       FILT_CYC = 4
) (
    input  logic             o_clk,
    input  logic             o_rst,
    input  logic [WIDTH-1:0] sync_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             chg_o
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("nv_nvdla_ssync_bank: WIDTH must be 1..32");
    end
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("nv_nvdla_ssync_bank: STAGES must be 2..4");
    end
    if (FILT_CYC < 1 || FILT_CYC > 255) begin : g_bad_filt
        $error("nv_nvdla_ssync_bank: FILT_CYC must be 1..255");
    end

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] sync_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic             chg_q;

    always_ff @(posedge o_clk or posedge o_rst) begin
        if (o_rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                stage_q[k] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= sync_i;
            for (int unsigned k = 1; k < STAGES; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign s = stage_q[STAGES-1];

`ifdef NVDLA_SSYNC_FILTER_EN
    localparam int unsigned    CW       = $clog2(FILT_CYC + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILT_CYC - 1);

    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] sync_q;

    // A channel only adopts the chain value after FILT_CYC consecutive cycles of disagreement.
    always_comb begin
        sync_d = sync_q;
        for (int unsigned n = 0; n < WIDTH; n++) begin
            cnt_d[n] = '0;
            if (s[n] == sync_q[n]) begin
                cnt_d[n] = '0;
            end else if (cnt_q[n] == CNT_LAST) begin
                sync_d[n] = s[n];
                cnt_d[n]  = '0;
            end else begin
                cnt_d[n] = cnt_q[n] + CW'(1);
            end
        end
    end

    always_ff @(posedge o_clk or posedge o_rst) begin
        if (o_rst) begin
            sync_q <= RST_VAL;
            for (int unsigned n = 0; n < WIDTH; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            sync_q <= sync_d;
            for (int unsigned n = 0; n < WIDTH; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    assign sync_o = sync_q;
`else
    // The next value of the last stage is the stage before it, so pulses land with the change.
    assign sync_d = stage_q[STAGES-2];
    assign sync_o = s;
`endif

    always_ff @(posedge o_clk or posedge o_rst) begin
        if (o_rst) begin
            rise_q <= '0;
            fall_q <= '0;
            chg_q  <= 1'b0;
        end else begin
            rise_q <= ~sync_o & sync_d;
            fall_q <= sync_o & ~sync_d;
            chg_q  <= |(sync_o ^ sync_d);
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign chg_o  = chg_q;

endmodule

// File: tb/tb_nv_nvdla_ssync_bank.sv
// Directed bench for nv_nvdla_ssync_bank; filter scenarios run when NVDLA_SSYNC_FILTER_EN is defined.
module tb_nv_nvdla_ssync_bank;

`ifdef NVDLA_SSYNC_FILTER_EN
    localparam int unsigned FADD   = 4;
    localparam int unsigned FADD_S = 1;
`else
    localparam int unsigned FADD   = 0;
    localparam int unsigned FADD_S = 0;
`endif
    localparam int unsigned LAT = 3 + FADD;
    localparam int unsigned L2  = 2 + FADD_S;
    localparam int unsigned L4  = 4 + FADD_S;

    logic       clk;
    logic       rst;
    logic [3:0] in1;
    logic [3:0] sync1, rise1, fall1;
    logic       chg1;
    logic       sw;
    logic       sync2, rise2, fall2, chg2;
    logic       sync4, rise4, fall4, chg4;

    int n_checks;
    int n_errors;
    logic [3:0] cur;

    nv_nvdla_ssync_bank #(.WIDTH(4), .STAGES(3), .RST_VAL(4'b1010), .FILT_CYC(4)) u_dut (
        .o_clk(clk), .o_rst(rst), .sync_i(in1),
        .sync_o(sync1), .rise_o(rise1), .fall_o(fall1), .chg_o(chg1)
    );

    nv_nvdla_ssync_bank #(.WIDTH(1), .STAGES(2), .RST_VAL(1'b0), .FILT_CYC(1)) u_s2 (
        .o_clk(clk), .o_rst(rst), .sync_i(sw),
        .sync_o(sync2), .rise_o(rise2), .fall_o(fall2), .chg_o(chg2)
    );

    nv_nvdla_ssync_bank #(.WIDTH(1), .STAGES(4), .RST_VAL(1'b0), .FILT_CYC(1)) u_s4 (
        .o_clk(clk), .o_rst(rst), .sync_i(sw),
        .sync_o(sync4), .rise_o(rise4), .fall_o(fall4), .chg_o(chg4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string tag, input logic [3:0] s, input logic [3:0] r,
                              input logic [3:0] f, input logic c);
        check_val({tag, "_sync"}, sync1, s);
        check_val({tag, "_rise"}, rise1, r);
        check_val({tag, "_fall"}, fall1, f);
        check_val({tag, "_chg"}, 4'(chg1), 4'(c));
    endtask

    // Apply a new level on the 4-channel DUT and check every edge up to one past the change.
    task automatic run_step(input string tag, input logic [3:0] nv, input int unsigned lat);
        logic [3:0] ov;
        ov  = cur;
        in1 = nv;
        for (int unsigned k = 1; k <= lat + 1; k++) begin
            tick();
            if (k < lat)
                check_main({tag, "_pre"}, ov, 4'b0000, 4'b0000, 1'b0);
            else if (k == lat)
                check_main({tag, "_at"}, nv, nv & ~ov, ov & ~nv, ov != nv);
            else
                check_main({tag, "_post"}, nv, 4'b0000, 4'b0000, 1'b0);
        end
        cur = nv;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        in1 = 4'b0101;
        sw  = 1'b0;
        cur = 4'b1010;

        repeat (3) tick();
        check_main("rst", 4'b1010, 4'b0000, 4'b0000, 1'b0);
        check_val("rst_s2", 4'(sync2), 4'b0000);
        check_val("rst_s4", 4'(sync4), 4'b0000);

        rst = 1'b0;
        run_step("rel", 4'b0101, LAT);

        sw = 1'b1;
        for (int unsigned k = 1; k <= 6 + FADD_S; k++) begin
            tick();
            check_val("lat2_sync", 4'(sync2), 4'(k >= L2));
            check_val("lat2_rise", 4'(rise2), 4'(k == L2));
            check_val("lat2_chg", 4'(chg2), 4'(k == L2));
            check_val("lat4_sync", 4'(sync4), 4'(k >= L4));
            check_val("lat4_rise", 4'(rise4), 4'(k == L4));
            check_val("lat4_fall", 4'(fall4), 4'b0000);
        end

        run_step("multi", 4'b1100, LAT);
        run_step("swap", 4'b0011, LAT);

`ifdef NVDLA_SSYNC_FILTER_EN
        // Three-cycle pulse on channel 2 must be swallowed by the filter.
        in1 = 4'b0111;
        repeat (3) tick();
        in1 = 4'b0011;
        for (int unsigned k = 1; k <= 12; k++) begin
            tick();
            check_main("rej", 4'b0011, 4'b0000, 4'b0000, 1'b0);
        end

        // High 2, low 1, then high held: edge 4 samples the final rise, sync follows at edge 10.
        in1 = 4'b0111;
        repeat (2) tick();
        in1 = 4'b0011;
        tick();
        in1 = 4'b0111;
        for (int unsigned k = 4; k <= 11; k++) begin
            tick();
            if (k < 10)
                check_main("rst_pre", 4'b0011, 4'b0000, 4'b0000, 1'b0);
            else if (k == 10)
                check_main("rst_at", 4'b0111, 4'b0100, 4'b0000, 1'b1);
            else
                check_main("rst_post", 4'b0111, 4'b0000, 4'b0000, 1'b0);
        end
        cur = 4'b0111;
`endif

        in1 = 4'b1100;
        repeat (2) tick();
        #3;
        rst = 1'b1;
        #1;
        check_main("arst", 4'b1010, 4'b0000, 4'b0000, 1'b0);
        check_val("arst_s2", 4'(sync2), 4'b0000);
        repeat (2) begin
            tick();
            check_main("arst_hold", 4'b1010, 4'b0000, 4'b0000, 1'b0);
        end
        rst = 1'b0;
        cur = 4'b1010;
        run_step("rerun", 4'b1100, LAT);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
